// File: rtl/asyn_fifo_pkg.sv
// Shared defaults and elaboration helpers for the async FIFO read-side blocks.
package asyn_fifo_pkg;

  localparam int DEF_WIDTH_FIFO = 8;
  localparam int DEF_ADDR_FIFO  = 3;
  localparam int DEF_DLY        = 1;

  // Ceiling log2, evaluated at elaboration for pointer and count widths.
  function automatic int clog2(input int value);
    int result;
    result = 0;
    for (int v = value - 1; v > 0; v = v >> 1) begin
      result = result + 1;
    end
    return result;
  endfunction

endpackage

// File: rtl/asyn_fifo_rd_buf.sv
// Circular skid buffer: DEPTH registered entries, push at wptr, head at rptr.
module asyn_fifo_rd_buf
  import asyn_fifo_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH_FIFO,
  parameter int DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           push_data,
  input  logic                       pop,
  output logic [clog2(DEPTH):0]      cnt,
  output logic                       head_valid,
  output logic [WIDTH-1:0]           head_data
);

  localparam int AW = clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [AW-1:0]             wptr_q, wptr_d;
  logic [AW-1:0]             rptr_q, rptr_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [DEPTH-1:0][WIDTH-1:0] mem_q, mem_d;

  always_comb begin
    wptr_d = push ? wptr_q + 1'b1 : wptr_q;
    rptr_d = pop ? rptr_q + 1'b1 : rptr_q;
    cnt_d  = cnt_q + CW'(push) - CW'(pop);
  end

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      assign mem_d[gi] = (push && (wptr_q == AW'(gi))) ? push_data : mem_q[gi];
    end
  endgenerate

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      mem_q  <= '0;
    end else begin
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
      mem_q  <= mem_d;
    end
  end

  assign cnt        = cnt_q;
  assign head_valid = (cnt_q != '0);
  assign head_data  = mem_q[rptr_q];

endmodule

// File: rtl/asyn_fifo_rd_stream.sv
// Turns the CDC FIFO read port (registered rdata) into a first-word-fall-through
// valid/ready stream. Optional popped-word counter under ASYN_FIFO_RD_CNT_EN.
module asyn_fifo_rd_stream
  import asyn_fifo_pkg::*;
#(
  parameter int WIDTH_FIFO = DEF_WIDTH_FIFO,
  parameter int BUF_DEPTH  = 2,
  parameter int DLY        = DEF_DLY
) (
  input  logic                  clk_r,
  input  logic                  rst,
  input  logic                  fifo_empty,
  input  logic [WIDTH_FIFO-1:0] fifo_rdata,
  output logic                  fifo_ren,
  output logic                  m_valid,
  input  logic                  m_ready,
  output logic [WIDTH_FIFO-1:0] m_data
`ifdef ASYN_FIFO_RD_CNT_EN
  ,
  output logic [15:0]           rd_cnt
`endif
);

  localparam int CW = clog2(BUF_DEPTH) + 1;
  localparam int LW = CW + 1;

  logic          inflight_q, inflight_d;
  logic          pop;
  logic [CW-1:0] cnt;
  logic [LW-1:0] level;

  assign pop = m_valid && m_ready;

  // Credit check counts buffered plus in-flight words, net of this cycle's pop;
  // pop implies cnt>=1 so the subtraction never wraps.
  always_comb begin
    level      = {1'b0, cnt} + LW'(inflight_q) - LW'(pop);
    fifo_ren   = !fifo_empty && (level < LW'(BUF_DEPTH));
    inflight_d = fifo_ren;
  end

  always_ff @(posedge clk_r or posedge rst) begin
    if (rst) begin
      inflight_q <= 1'b0;
    end else begin
      inflight_q <= inflight_d;
    end
  end

  asyn_fifo_rd_buf #(
    .WIDTH (WIDTH_FIFO),
    .DEPTH (BUF_DEPTH)
  ) u_buf (
    .clk        (clk_r),
    .rst        (rst),
    .push       (inflight_q),
    .push_data  (fifo_rdata),
    .pop        (pop),
    .cnt        (cnt),
    .head_valid (m_valid),
    .head_data  (m_data)
  );

  // DLY only matters to delay-annotated FIFO models; register updates here are zero-delay.
  generate
    if (DLY < 0) begin : g_dly_ignored
    end
  endgenerate

`ifdef ASYN_FIFO_RD_CNT_EN
  logic [15:0] rd_cnt_q, rd_cnt_d;

  always_comb begin
    rd_cnt_d = pop ? rd_cnt_q + 16'd1 : rd_cnt_q;
  end

  always_ff @(posedge clk_r or posedge rst) begin
    if (rst) begin
      rd_cnt_q <= '0;
    end else begin
      rd_cnt_q <= rd_cnt_d;
    end
  end

  assign rd_cnt = rd_cnt_q;
`endif

endmodule
